// File: rtl/regfile_mp.sv
// Multi-read-port register file with write bypass, hardwired zero register,
// per-register pending bits for hazard detection and optional registered reads.
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int READ_REG = 1,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     pend_set,
    input  logic [ADDR_W-1:0]        pend_addr
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0][DATA_W-1:0] mem_q;
    logic [DEPTH-1:0]             pend_q;
    logic [DEPTH-1:0]             pend_d;
    logic                         we;
    logic                         pset;
    logic [NUM_RD*DATA_W-1:0]     rv;
    logic [NUM_RD-1:0]            bv;

    assign we   = wr_en    && !((ZERO_REG != 0) && (wr_addr   == '0));
    assign pset = pend_set && !((ZERO_REG != 0) && (pend_addr == '0));

    // Clear before set so a new producer issued on the retiring edge stays outstanding.
    always_comb begin
        pend_d = pend_q;
        if (we) begin
            pend_d[wr_addr] = 1'b0;
        end
        if (pset) begin
            pend_d[pend_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q  <= '0;
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
            if (we) begin
                mem_q[wr_addr] <= wr_data;
            end
        end
    end

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic              hit;
        logic              zero;

        assign ra   = rd_addr[g*ADDR_W +: ADDR_W];
        assign zero = (ZERO_REG != 0) && (ra == '0);
        assign hit  = (BYPASS != 0) && we && (wr_addr == ra);
        assign rv[g*DATA_W +: DATA_W] = zero ? '0 : (hit ? wr_data : mem_q[ra]);
        // A write landing this cycle already satisfies the hazard.
        assign bv[g] = pend_q[ra] && !hit;
    end

    if (READ_REG != 0) begin : g_reg
        logic [NUM_RD*DATA_W-1:0] rd_data_q;
        logic [NUM_RD-1:0]        rd_busy_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rd_data_q <= '0;
                rd_busy_q <= '0;
            end else begin
                rd_data_q <= rv;
                rd_busy_q <= bv;
            end
        end

        assign rd_data = rd_data_q;
        assign rd_busy = rd_busy_q;
    end else begin : g_comb
        assign rd_data = rv;
        assign rd_busy = bv;
    end
endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: three instances (registered+bypass, registered without
// bypass, combinational+bypass) driven in parallel and checked against a model.
module tb_regfile_mp;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  rd_addr;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        pend_set;
    logic [4:0]  pend_addr;

    logic [63:0] rd_data_a, rd_data_b, rd_data_c;
    logic [1:0]  rd_busy_a, rd_busy_b, rd_busy_c;

    int checks   = 0;
    int failures = 0;

    logic [31:0] m_mem [32];
    bit          m_pend [32];

    logic [63:0] exp_a_d, exp_b_d, exp_c_d, obs_c_d;
    logic [1:0]  exp_a_b, exp_b_b, exp_c_b, obs_c_b;

    always #5 clk = ~clk;

    regfile_mp #(.READ_REG(1), .BYPASS(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_busy(rd_busy_a),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .pend_set(pend_set), .pend_addr(pend_addr));
    regfile_mp #(.READ_REG(1), .BYPASS(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .pend_set(pend_set), .pend_addr(pend_addr));
    regfile_mp #(.READ_REG(0), .BYPASS(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_c), .rd_busy(rd_busy_c),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .pend_set(pend_set), .pend_addr(pend_addr));

    // Reference read: register 0 is zero, a matching write is forwarded, else array contents.
    function automatic void model_read(input bit byp, output logic [63:0] d, output logic [1:0] b);
        for (int p = 0; p < 2; p++) begin
            int a;
            bit fwd;
            a   = int'(rd_addr[p*5 +: 5]);
            fwd = byp && wr_en && (wr_addr != 0) && (int'(wr_addr) == a);
            d[p*32 +: 32] = (a == 0) ? 32'h0 : (fwd ? wr_data : m_mem[a]);
            b[p] = m_pend[a] && !fwd;
        end
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < 32; i++) begin
            m_mem[i]  = 32'h0;
            m_pend[i] = 1'b0;
        end
    endfunction

    // One clock: sample the combinational instance and compute expectations at the
    // falling edge, then advance the model on the rising edge.
    task automatic tick();
        @(negedge clk);
        model_read(1'b1, exp_c_d, exp_c_b);
        model_read(1'b1, exp_a_d, exp_a_b);
        model_read(1'b0, exp_b_d, exp_b_b);
        obs_c_d = rd_data_c;
        obs_c_b = rd_busy_c;
        @(posedge clk);
        if (wr_en && wr_addr != 0) begin
            m_mem[wr_addr]  = wr_data;
            m_pend[wr_addr] = 1'b0;
        end
        if (pend_set && pend_addr != 0) m_pend[pend_addr] = 1'b1;
        #1;
    endtask

    task automatic idle_inputs();
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; pend_set = 1'b0; pend_addr = '0; rd_addr = '0;
    endtask

    task automatic test_reset();
        logic [197:0] all_out;
        idle_inputs();
        rst_n = 1'b0;
        model_clear();
        #3;
        all_out = {rd_data_a, rd_busy_a, rd_data_b, rd_busy_b, rd_data_c, rd_busy_c};
        checks++;
        if (all_out !== '0) begin
            failures++; $display("FAIL reset_outputs got %h required 0", all_out);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        for (int a = 0; a < 32; a++) begin
            rd_addr = {5'(31 - a), 5'(a)};
            tick();
            checks += 2;
            if ({rd_data_a, rd_busy_a} !== 66'h0) begin
                failures++; $display("FAIL reset_read_a addr=%0d got %h required 0", a, {rd_data_a, rd_busy_a});
            end
            if ({rd_data_b, rd_busy_b, obs_c_d, obs_c_b} !== 132'h0) begin
                failures++; $display("FAIL reset_read_bc addr=%0d got %h required 0", a, {rd_data_b, rd_busy_b, obs_c_d, obs_c_b});
            end
        end
    endtask

    task automatic test_write_read();
        idle_inputs();
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
        tick();
        idle_inputs();
        rd_addr = {5'd5, 5'd5};
        tick();
        checks += 2;
        if (rd_data_a !== {2{32'hDEADBEEF}}) begin
            failures++; $display("FAIL write_read_a got %h required %h", rd_data_a, {2{32'hDEADBEEF}});
        end
        if ({rd_data_b, obs_c_d} !== {4{32'hDEADBEEF}}) begin
            failures++; $display("FAIL write_read_bc got %h required %h", {rd_data_b, obs_c_d}, {4{32'hDEADBEEF}});
        end
        wr_en = 1'b0; wr_addr = 5'd5; wr_data = 32'h12345678;
        tick();
        tick();
        checks += 2;
        if (rd_data_a !== {2{32'hDEADBEEF}}) begin
            failures++; $display("FAIL wr_en_low_a got %h required %h", rd_data_a, {2{32'hDEADBEEF}});
        end
        if (obs_c_d !== {2{32'hDEADBEEF}}) begin
            failures++; $display("FAIL wr_en_low_c got %h required %h", obs_c_d, {2{32'hDEADBEEF}});
        end
    endtask

    task automatic test_zero_reg();
        idle_inputs();
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF; pend_set = 1'b1; pend_addr = 5'd0;
        tick();
        idle_inputs();
        tick();
        tick();
        checks += 2;
        if ({rd_data_a, rd_busy_a, rd_data_b, rd_busy_b} !== 132'h0) begin
            failures++; $display("FAIL zero_reg_ab got %h required 0", {rd_data_a, rd_busy_a, rd_data_b, rd_busy_b});
        end
        if ({obs_c_d, obs_c_b} !== 66'h0) begin
            failures++; $display("FAIL zero_reg_c got %h required 0", {obs_c_d, obs_c_b});
        end
    endtask

    task automatic test_bypass();
        idle_inputs();
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hA5A5A5A5; rd_addr = {5'd7, 5'd0};
        tick();
        checks += 3;
        if (rd_data_a[63:32] !== 32'hA5A5A5A5) begin
            failures++; $display("FAIL bypass_on got %h required a5a5a5a5", rd_data_a[63:32]);
        end
        if (rd_data_b[63:32] !== 32'h0) begin
            failures++; $display("FAIL bypass_off got %h required 0", rd_data_b[63:32]);
        end
        if (obs_c_d[63:32] !== 32'hA5A5A5A5) begin
            failures++; $display("FAIL bypass_comb got %h required a5a5a5a5", obs_c_d[63:32]);
        end
    endtask

    task automatic test_scoreboard();
        idle_inputs();
        pend_set = 1'b1; pend_addr = 5'd9;
        tick();
        idle_inputs(); rd_addr = {5'd9, 5'd9};
        tick();
        checks++;
        if ({rd_busy_a, rd_busy_b, obs_c_b} !== 6'b111111) begin
            failures++; $display("FAIL pend_busy got %b required 111111", {rd_busy_a, rd_busy_b, obs_c_b});
        end
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h11;
        tick();
        checks++;
        if ({rd_busy_a, rd_busy_b, obs_c_b} !== 6'b001100) begin
            failures++; $display("FAIL write_cycle_busy got %b required 001100", {rd_busy_a, rd_busy_b, obs_c_b});
        end
        idle_inputs(); rd_addr = {5'd9, 5'd9};
        tick();
        checks++;
        if ({rd_busy_a, rd_busy_b, obs_c_b, rd_data_a[31:0]} !== {6'b000000, 32'h11}) begin
            failures++; $display("FAIL after_write got %h required %h", {rd_busy_a, rd_busy_b, obs_c_b, rd_data_a[31:0]}, {6'b000000, 32'h11});
        end
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h22; pend_set = 1'b1; pend_addr = 5'd9;
        tick();
        idle_inputs(); rd_addr = {5'd9, 5'd9};
        tick();
        checks++;
        if ({rd_busy_a, rd_busy_b, obs_c_b, rd_data_a[31:0]} !== {6'b111111, 32'h22}) begin
            failures++; $display("FAIL set_wins got %h required %h", {rd_busy_a, rd_busy_b, obs_c_b, rd_data_a[31:0]}, {6'b111111, 32'h22});
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            wr_en     = 1'($urandom_range(0, 1));
            wr_addr   = 5'($urandom_range(0, 7));
            wr_data   = $urandom;
            pend_set  = 1'($urandom_range(0, 1));
            pend_addr = 5'($urandom_range(0, 7));
            rd_addr   = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            if (n % 50 == 49) rd_addr = {5'($urandom_range(0, 31)), 5'($urandom_range(0, 31))};
            tick();
            checks += 3;
            if ({rd_data_a, rd_busy_a} !== {exp_a_d, exp_a_b}) begin
                failures++; $display("FAIL random_a n=%0d got %h required %h", n, {rd_data_a, rd_busy_a}, {exp_a_d, exp_a_b});
            end
            if ({rd_data_b, rd_busy_b} !== {exp_b_d, exp_b_b}) begin
                failures++; $display("FAIL random_b n=%0d got %h required %h", n, {rd_data_b, rd_busy_b}, {exp_b_d, exp_b_b});
            end
            if ({obs_c_d, obs_c_b} !== {exp_c_d, exp_c_b}) begin
                failures++; $display("FAIL random_c n=%0d got %h required %h", n, {obs_c_d, obs_c_b}, {exp_c_d, exp_c_b});
            end
        end
    endtask

    task automatic test_async_reset();
        logic [197:0] all_out;
        idle_inputs();
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h55; pend_set = 1'b1; pend_addr = 5'd4;
        tick();
        idle_inputs(); rd_addr = {5'd4, 5'd3};
        #2;
        checks++;
        if ({rd_data_c[31:0], rd_busy_c[1]} !== {32'h55, 1'b1}) begin
            failures++; $display("FAIL pre_reset got %h required %h", {rd_data_c[31:0], rd_busy_c[1]}, {32'h55, 1'b1});
        end
        rst_n = 1'b0;
        model_clear();
        #1;
        all_out = {rd_data_a, rd_busy_a, rd_data_b, rd_busy_b, rd_data_c, rd_busy_c};
        checks++;
        if (all_out !== '0) begin
            failures++; $display("FAIL async_reset got %h required 0", all_out);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();
        tick();
        checks += 2;
        if ({rd_data_a, rd_busy_a, rd_data_b, rd_busy_b} !== 132'h0) begin
            failures++; $display("FAIL post_reset_ab got %h required 0", {rd_data_a, rd_busy_a, rd_data_b, rd_busy_b});
        end
        if ({obs_c_d, obs_c_b} !== 66'h0) begin
            failures++; $display("FAIL post_reset_c got %h required 0", {obs_c_d, obs_c_b});
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_zero_reg();
        test_bypass();
        test_scoreboard();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
